// File: rtl/sum_latch_uart_pkg.sv
// Shared types, constants and width helpers for the sum-latch UART core.
package sum_latch_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  function automatic int unsigned calc_sum_w(input int unsigned data_w,
                                             input int unsigned num_ops);
    int unsigned w;
    w = data_w + $clog2(num_ops);
    return (w < data_w + 1) ? data_w + 1 : w;
  endfunction

  function automatic int unsigned calc_num_bytes(input int unsigned sum_w);
    return (sum_w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter; accepts a new byte in IDLE or in the last stop cycle.
module uart_tx_8n1
  import sum_latch_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       txd,
  output logic       tx_done
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLoad = CntW'(CLKS_PER_BIT - 1);

  tx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            txd_q, txd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          cnt_d   = CntLoad;
          shreg_d = tx_byte;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = CntLoad;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CntLoad;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          tx_done = 1'b1;
          // Chaining straight into START keeps multi-byte frames gap-free.
          if (tx_start) begin
            state_d = START;
            cnt_d   = CntLoad;
            shreg_d = tx_byte;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = UART_START;
      DATA:    txd_d = shreg_d[0];
      default: txd_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'd0;
      txd_q   <= UART_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: rtl/sum_latch_uart_core.sv
// Latches NUM_OPS operands on synchronised save strobes, keeps their running sum and
// transmits it over UART (LSB byte first) after every save.
module sum_latch_uart_core
  import sum_latch_uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned NUM_OPS      = 2,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2,
  localparam int unsigned SUM_W       = calc_sum_w(DATA_W, NUM_OPS),
  localparam int unsigned NUM_BYTES   = calc_num_bytes(SUM_W)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_OPS-1:0] save_n,
  input  logic [DATA_W-1:0]  data_input,
  output logic               uart_txd,
  output logic               uart_tx_busy,
  output logic [SUM_W-1:0]   sum_out
);

  localparam int unsigned SnapW = NUM_BYTES * 8;
  localparam int unsigned IdxW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  logic [SYNC_STAGES-1:0][NUM_OPS-1:0] sync_q;
  logic [NUM_OPS-1:0]                  prev_q, save_pulse;
  logic [NUM_OPS-1:0][DATA_W-1:0]      operand_q;
  logic                                save_seen_q;
  logic [SUM_W-1:0]                    sum_d, sum_q;
  logic                                pending_q, active_q;
  logic [SnapW-1:0]                    snap_q, sum_ext;
  logic [IdxW-1:0]                     byte_idx_q;
  logic                                start_new, start_next, last_byte;
  logic                                tx_start, tx_done;
  logic [7:0]                          tx_byte;

  // Released level is 1, so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], save_n};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign save_pulse = prev_q & ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      operand_q   <= '0;
      save_seen_q <= 1'b0;
    end else begin
      save_seen_q <= |save_pulse;
      for (int k = 0; k < NUM_OPS; k++) begin
        if (save_pulse[k]) operand_q[k] <= data_input;
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < NUM_OPS; k++) sum_d = sum_d + SUM_W'(operand_q[k]);
  end

  assign sum_ext    = SnapW'(sum_q);
  assign last_byte  = (byte_idx_q == IdxW'(NUM_BYTES - 1));
  assign start_new  = pending_q & ~active_q;
  assign start_next = tx_done & ~last_byte;
  assign tx_start   = start_new | start_next;
  assign tx_byte    = start_new ? sum_ext[7:0] : snap_q[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q      <= '0;
      pending_q  <= 1'b0;
      active_q   <= 1'b0;
      snap_q     <= '0;
      byte_idx_q <= '0;
    end else begin
      sum_q <= sum_d;
      // A save landing while a frame starts must not be lost: set wins over clear.
      if (save_seen_q)    pending_q <= 1'b1;
      else if (start_new) pending_q <= 1'b0;
      if (start_new)                  active_q <= 1'b1;
      else if (tx_done && last_byte)  active_q <= 1'b0;
      if (start_new) begin
        snap_q     <= sum_ext >> 8;
        byte_idx_q <= '0;
      end else if (start_next) begin
        snap_q     <= snap_q >> 8;
        byte_idx_q <= byte_idx_q + 1'b1;
      end
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_start(tx_start),
    .tx_byte (tx_byte),
    .txd     (uart_txd),
    .tx_done (tx_done)
  );

  assign uart_tx_busy = active_q;
  assign sum_out      = sum_q;

endmodule

// File: tb/tb_sum_latch_uart_core.sv
// Directed bench: a 2x4-bit core and a 3x12-bit core, both at 4 clocks per UART bit.
module tb_sum_latch_uart_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, txd_a, busy_a;
  logic [1:0] save_a;
  logic [3:0] data_a;
  logic [4:0] sum_a;

  logic        reset_b, txd_b, busy_b;
  logic [2:0]  save_b;
  logic [11:0] data_b;
  logic [13:0] sum_b;

  int compared = 0;
  int mismatched = 0;

  sum_latch_uart_core #(.DATA_W(4), .NUM_OPS(2), .CLKS_PER_BIT(4), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset_n(reset_a), .save_n(save_a), .data_input(data_a),
    .uart_txd(txd_a), .uart_tx_busy(busy_a), .sum_out(sum_a)
  );

  sum_latch_uart_core #(.DATA_W(12), .NUM_OPS(3), .CLKS_PER_BIT(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset_n(reset_b), .save_n(save_b), .data_input(data_b),
    .uart_txd(txd_b), .uart_tx_busy(busy_b), .sum_out(sum_b)
  );

  function automatic logic txd_of(input int which);
    return (which == 1) ? txd_b : txd_a;
  endfunction

  // Waits (bounded) for a start bit, then samples each bit one cycle into its period.
  // Returns at the second cycle of the stop bit.
  task automatic rx(input int which, output logic [7:0] b, output bit ok);
    int n = 0;
    ok = 1'b1;
    b  = 8'h00;
    while (txd_of(which) === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      ok = 1'b0;
      return;
    end
    repeat (5) @(negedge clk);
    b[0] = txd_of(which);
    for (int i = 1; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = txd_of(which);
    end
    repeat (4) @(negedge clk);
    if (txd_of(which) !== 1'b1) ok = 1'b0;
  endtask

  task automatic reset_dut_a();
    save_a  = 2'b11;
    reset_a = 1'b0;
    repeat (3) @(negedge clk);
    reset_a = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    int busy_seen = 0;
    save_a  = 2'b11;
    data_a  = 4'h0;
    reset_a = 1'b0;
    @(negedge clk);
    compared++;
    if (txd_a !== 1'b1) begin mismatched++; $display("FAIL reset_txd: got %b want 1", txd_a); end
    compared++;
    if (busy_a !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    compared++;
    if (sum_a !== 5'h00) begin mismatched++; $display("FAIL reset_sum: got %h want 00", sum_a); end
    reset_a = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy_a !== 1'b0) busy_seen++;
    end
    compared++;
    if (busy_seen !== 0) begin
      mismatched++; $display("FAIL reset_release_no_frame: busy cycles %0d want 0", busy_seen);
    end
  endtask

  task automatic test_two_operand();
    logic [7:0] b;
    bit ok;
    data_a = 4'h9;
    save_a = 2'b10;
    repeat (3) @(negedge clk);
    compared++;
    if (sum_a !== 5'h00) begin mismatched++; $display("FAIL sum_at_e1: got %h want 00", sum_a); end
    @(negedge clk);
    compared++;
    if (sum_a !== 5'h09) begin mismatched++; $display("FAIL sum_at_e2: got %h want 09", sum_a); end
    compared++;
    if (txd_a !== 1'b1) begin mismatched++; $display("FAIL txd_at_e2: got %b want 1", txd_a); end
    @(negedge clk);
    compared++;
    if (txd_a !== 1'b0 || busy_a !== 1'b1) begin
      mismatched++; $display("FAIL start_at_e3: txd %b busy %b want txd 0 busy 1", txd_a, busy_a);
    end
    save_a = 2'b11;
    rx(0, b, ok);
    compared++;
    if (!ok || b !== 8'h09) begin mismatched++; $display("FAIL frame_op0: got %h ok %0d want 09", b, ok); end
    repeat (3) @(negedge clk);
    compared++;
    if (busy_a !== 1'b0) begin mismatched++; $display("FAIL busy_after_frame: got %b want 0", busy_a); end
    data_a = 4'hC;
    save_a = 2'b01;
    repeat (3) @(negedge clk);
    save_a = 2'b11;
    rx(0, b, ok);
    compared++;
    if (!ok || b !== 8'h15) begin mismatched++; $display("FAIL frame_sum: got %h ok %0d want 15", b, ok); end
    compared++;
    if (sum_a !== 5'h15) begin mismatched++; $display("FAIL sum_two_op: got %h want 15", sum_a); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_save_during_tx();
    logic [7:0] b;
    bit ok;
    int busy_seen = 0;
    reset_dut_a();
    data_a = 4'h3;
    save_a = 2'b10;
    fork
      rx(0, b, ok);
      begin
        repeat (3) @(negedge clk);
        save_a = 2'b11;
        repeat (17) @(negedge clk);
        data_a = 4'h4;
        save_a = 2'b01;
        repeat (3) @(negedge clk);
        save_a = 2'b11;
        repeat (5) @(negedge clk);
        data_a = 4'h5;
        save_a = 2'b01;
        repeat (3) @(negedge clk);
        save_a = 2'b11;
      end
    join
    compared++;
    if (!ok || b !== 8'h03) begin mismatched++; $display("FAIL inflight_frame: got %h ok %0d want 03", b, ok); end
    repeat (3) @(negedge clk);
    compared++;
    if (busy_a !== 1'b0) begin mismatched++; $display("FAIL busy_gap_low: got %b want 0", busy_a); end
    @(negedge clk);
    compared++;
    if (busy_a !== 1'b1 || txd_a !== 1'b0) begin
      mismatched++; $display("FAIL busy_gap_rerise: busy %b txd %b want 1 0", busy_a, txd_a);
    end
    rx(0, b, ok);
    compared++;
    if (!ok || b !== 8'h08) begin mismatched++; $display("FAIL retransmit: got %h ok %0d want 08", b, ok); end
    repeat (3) @(negedge clk);
    repeat (120) begin
      @(negedge clk);
      if (busy_a !== 1'b0) busy_seen++;
    end
    compared++;
    if (busy_seen !== 0) begin mismatched++; $display("FAIL no_third_frame: busy cycles %0d want 0", busy_seen); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] b;
    bit ok;
    int busy_seen = 0;
    reset_dut_a();
    data_a = 4'h7;
    save_a = 2'b00;
    repeat (3) @(negedge clk);
    save_a = 2'b11;
    rx(0, b, ok);
    compared++;
    if (!ok || b !== 8'h0E) begin mismatched++; $display("FAIL simul_frame: got %h ok %0d want 0e", b, ok); end
    compared++;
    if (sum_a !== 5'h0E) begin mismatched++; $display("FAIL simul_sum: got %h want 0e", sum_a); end
    repeat (3) @(negedge clk);
    repeat (100) begin
      @(negedge clk);
      if (busy_a !== 1'b0) busy_seen++;
    end
    compared++;
    if (busy_seen !== 0) begin mismatched++; $display("FAIL simul_single_frame: busy cycles %0d want 0", busy_seen); end
  endtask

  task automatic test_reset_mid_frame();
    int n = 0;
    int activity = 0;
    reset_dut_a();
    data_a = 4'h5;
    save_a = 2'b10;
    while (txd_a === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    save_a = 2'b11;
    compared++;
    if (n >= 100) begin mismatched++; $display("FAIL midreset_start: no start bit within %0d cycles", n); end
    repeat (17) @(negedge clk);
    #2 reset_a = 1'b0;
    #1;
    compared++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0 || sum_a !== 5'h00) begin
      mismatched++;
      $display("FAIL midreset_async: txd %b busy %b sum %h want 1 0 00", txd_a, busy_a, sum_a);
    end
    @(negedge clk);
    reset_a = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || txd_a !== 1'b1) activity++;
    end
    compared++;
    if (activity !== 0) begin mismatched++; $display("FAIL midreset_no_resend: active cycles %0d want 0", activity); end
  endtask

  task automatic test_held_strobe();
    logic [7:0] b;
    bit ok;
    int busy_seen = 0;
    reset_dut_a();
    data_a = 4'h6;
    save_a = 2'b10;
    rx(0, b, ok);
    compared++;
    if (!ok || b !== 8'h06) begin mismatched++; $display("FAIL held_frame: got %h ok %0d want 06", b, ok); end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      if (i == 55) save_a = 2'b11;
      @(negedge clk);
      if (busy_a !== 1'b0) busy_seen++;
    end
    compared++;
    if (busy_seen !== 0) begin mismatched++; $display("FAIL held_single_frame: busy cycles %0d want 0", busy_seen); end
    compared++;
    if (sum_a !== 5'h06) begin mismatched++; $display("FAIL held_sum: got %h want 06", sum_a); end
  endtask

  task automatic test_multi_byte();
    logic [7:0] b;
    bit ok;
    int busy_low = 0;
    data_b = 12'hFFF;
    save_b = 3'b110;
    repeat (3) @(negedge clk);
    save_b = 3'b111;
    repeat (100) @(negedge clk);
    compared++;
    if (sum_b !== 14'h0FFF) begin mismatched++; $display("FAIL mb_sum1: got %h want 0fff", sum_b); end
    save_b = 3'b101;
    repeat (3) @(negedge clk);
    save_b = 3'b111;
    repeat (100) @(negedge clk);
    compared++;
    if (sum_b !== 14'h1FFE) begin mismatched++; $display("FAIL mb_sum2: got %h want 1ffe", sum_b); end
    save_b = 3'b011;
    repeat (3) @(negedge clk);
    save_b = 3'b111;
    rx(1, b, ok);
    compared++;
    if (!ok || b !== 8'hFD) begin mismatched++; $display("FAIL mb_byte0: got %h ok %0d want fd", b, ok); end
    repeat (3) begin
      @(negedge clk);
      if (busy_b !== 1'b1) busy_low++;
    end
    compared++;
    if (busy_low !== 0 || txd_b !== 1'b0) begin
      mismatched++; $display("FAIL mb_no_gap: busy low %0d txd %b want 0 0", busy_low, txd_b);
    end
    rx(1, b, ok);
    compared++;
    if (!ok || b !== 8'h2F) begin mismatched++; $display("FAIL mb_byte1: got %h ok %0d want 2f", b, ok); end
    compared++;
    if (sum_b !== 14'h2FFD) begin mismatched++; $display("FAIL mb_sum3: got %h want 2ffd", sum_b); end
    repeat (3) @(negedge clk);
    compared++;
    if (busy_b !== 1'b0) begin mismatched++; $display("FAIL mb_busy_end: got %b want 0", busy_b); end
  endtask

  initial begin
    reset_a = 1'b0;
    reset_b = 1'b0;
    save_a  = 2'b11;
    save_b  = 3'b111;
    data_a  = 4'h0;
    data_b  = 12'h000;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    test_reset();
    test_two_operand();
    test_save_during_tx();
    test_simultaneous();
    test_reset_mid_frame();
    test_held_strobe();
    test_multi_byte();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
